dcache_access_ctrl: RTL and testbench
=====================================

# dcache_access_ctrl

Data-side access sequencer sitting directly downstream of the pipeline's mem stage and upstream of the data cache. It latches one memory request per transaction and drives the dcache port. For LDI/STI it performs the two-access indirect sequence: a pointer read, then the final read or write at the pointer. It returns completion, read data and the fetched pointer to the mem stage, which holds its request and stalls until completion.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, and reset is synchronous and active-high
- req_read  in  1  mem stage read request (already qualified by valid)
- req_write  in  1  mem stage write request (already qualified by valid)
- req_indirect  in  1  1 = LDI/STI; perform pointer fetch first
- req_address  in  16  effective address, or pointer address when indirect
- req_wdata  in  16  store data
- req_byte_enable  in  2  byte lanes for a direct access
- dc_address  out  16  dcache address
- dc_read  out  1  dcache read strobe, held until dc_resp
- dc_write  out  1  dcache write strobe, held until dc_resp
- dc_wdata  out  16  dcache write data
- dc_byte_enable  out  2  dcache byte lanes
- dc_rdata  in  16  dcache read data, valid with dc_resp
- dc_resp  in  1  dcache completion, one-cycle pulse
- resp  out  1  one-cycle completion pulse to mem stage
- rdata  out  16  final read data, held until next completed read
- indirect_data  out  16  fetched pointer, held until next pointer fetch
- busy  out  1  transaction in flight (state != IDLE)

## Operation
- States: IDLE, PTR (pointer read), ACCESS (final or direct access), DONE.
- IDLE: if req_read or req_write, capture address, wdata, byte_enable, indirect and the rw type into internal registers.
  - If indirect, go to PTR; otherwise go to ACCESS.
  - If req_read and req_write are both high, the transaction is treated as a write.
- PTR: dc_read=1, dc_write=0, dc_address=captured address with bit0 forced to 0, dc_byte_enable=2'b11.
  - On dc_resp: indirect_data <= dc_rdata; go to ACCESS.
- ACCESS, direct: dc_address=captured address, dc_byte_enable=captured byte_enable, dc_read/dc_write per captured type, dc_wdata=captured wdata.
- ACCESS, indirect: dc_address={indirect_data[15:1],1'b0}, dc_byte_enable=2'b11.
- ACCESS, any: on dc_resp, if the access is a read, rdata <= dc_rdata. Go to DONE.
- DONE: resp=1 for this cycle only. Go to IDLE; no request is accepted in DONE.
- dc_* strobes are 0 in IDLE and DONE. dc_address, dc_wdata and dc_byte_enable are 0 in those states.
- dc_resp outside PTR/ACCESS is ignored.
- req_* changes after capture are ignored until the next IDLE.
- The mem stage must hold its request until resp. The block never issues a second transaction for the same held request, because DONE always returns to IDLE.
  - The mem stage drops its request in the cycle after resp. A request still high in IDLE is a new transaction.
- Reset at any state: next state IDLE and all outputs 0, including rdata and indirect_data. An in-flight dcache access is abandoned (strobes low the cycle after reset is sampled).

## Timing
- Request sampled in IDLE at edge 0; dc strobe asserted from cycle 1.
- Direct access: dc_resp in cycle k gives resp in cycle k+1. Minimum latency is dc_resp in cycle 1, resp in cycle 2.
- Indirect access:
  - PTR occupies cycle 1 until the first dc_resp.
  - The final strobe is asserted in the cycle after the first dc_resp.
  - resp comes one cycle after the second dc_resp. Minimum: resp in cycle 3.
- Strobes drop in the cycle after dc_resp; there is no back-to-back strobe across transactions.
- Earliest next acceptance is the cycle after resp.
- rdata and indirect_data are registered, valid from the resp cycle (indirect_data from the cycle after the pointer dc_resp).
- busy rises in cycle 1 and falls in the cycle after resp.

## Test plan
- Direct read:
  - Stimulus: req_read, addr 0x1234, be 2'b11; dc_resp with dc_rdata 0xBEEF in cycle 3.
  - Required: dc_read=1 and dc_address=0x1234 in cycles 1-3; resp and rdata=0xBEEF in cycle 4; busy low in cycle 5.
- Direct byte write:
  - Stimulus: req_write, addr 0x2001, wdata 0x00AB, be 2'b10; immediate dc_resp.
  - Required: dc_write=1, dc_wdata=0x00AB, dc_byte_enable=2'b10 in cycle 1; resp in cycle 2; rdata unchanged.
- LDI:
  - Stimulus: req_read with indirect, addr 0x3001; pointer dc_rdata 0x4567; final dc_rdata 0x9999.
  - Required: pointer read at 0x3000 with be 11; indirect_data=0x4567; final read at 0x4566; rdata=0x9999; exactly one resp.
- STI:
  - Stimulus: req_write with indirect, addr 0x5000, wdata 0x1111; pointer 0x6000.
  - Required: a read at 0x5000, then a write at 0x6000 with wdata 0x1111 and be 11, then resp.
- Reset mid-PTR:
  - Stimulus: assert reset while dc_read is high.
  - Required: the next cycle has all outputs 0 and state IDLE; a stray dc_resp afterwards gives no resp.
- Simultaneous read+write, and request held past resp:
  - Required: read+write is treated as a write; a request still held in the cycle after resp (IDLE) starts exactly one new transaction.

Source files
------------

// File: rtl/dcache_access_ctrl_if.sv
// rtl/dcache_access_ctrl_if.sv - mem-stage request, dcache port and completion signals
// master = mem stage plus dcache side of the world, slave = dcache_access_ctrl.
interface dcache_access_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic        req_indirect;
  logic [15:0] req_address;
  logic [15:0] req_wdata;
  logic [1:0]  req_byte_enable;
  logic [15:0] dc_address;
  logic        dc_read;
  logic        dc_write;
  logic [15:0] dc_wdata;
  logic [1:0]  dc_byte_enable;
  logic [15:0] dc_rdata;
  logic        dc_resp;
  logic        resp;
  logic [15:0] rdata;
  logic [15:0] indirect_data;
  logic        busy;

  modport master (
    output req_read, req_write, req_indirect, req_address, req_wdata, req_byte_enable,
    output dc_rdata, dc_resp,
    input  dc_address, dc_read, dc_write, dc_wdata, dc_byte_enable,
    input  resp, rdata, indirect_data, busy
  );

  modport slave (
    input  req_read, req_write, req_indirect, req_address, req_wdata, req_byte_enable,
    input  dc_rdata, dc_resp,
    output dc_address, dc_read, dc_write, dc_wdata, dc_byte_enable,
    output resp, rdata, indirect_data, busy
  );
endinterface

// File: rtl/dcache_access_ctrl.sv
// rtl/dcache_access_ctrl.sv - data-side access sequencer between mem stage and dcache
// Latches one request, runs the optional pointer fetch for LDI/STI, then the final access.
module dcache_access_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  dcache_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        ind_q, ind_d;
  logic        wr_q, wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] ind_data_q, ind_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      ind_q      <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      ind_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      ind_q      <= ind_d;
      wr_q       <= wr_d;
      rdata_q    <= rdata_d;
      ind_data_q <= ind_data_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    be_d               = be_q;
    ind_d              = ind_q;
    wr_d               = wr_q;
    rdata_d            = rdata_q;
    ind_data_d         = ind_data_q;
    bus.dc_address     = '0;
    bus.dc_read        = 1'b0;
    bus.dc_write       = 1'b0;
    bus.dc_wdata       = '0;
    bus.dc_byte_enable = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_read || bus.req_write) begin
          addr_d  = bus.req_address;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_byte_enable;
          ind_d   = bus.req_indirect;
          // read+write together resolves to a write
          wr_d    = bus.req_write;
          state_d = bus.req_indirect ? PTR : ACCESS;
        end
      end
      PTR: begin
        bus.dc_read        = 1'b1;
        bus.dc_address     = {addr_q[15:1], 1'b0};
        bus.dc_byte_enable = 2'b11;
        if (bus.dc_resp) begin
          ind_data_d = bus.dc_rdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        bus.dc_read        = ~wr_q;
        bus.dc_write       = wr_q;
        bus.dc_wdata       = wdata_q;
        bus.dc_address     = ind_q ? {ind_data_q[15:1], 1'b0} : addr_q;
        bus.dc_byte_enable = ind_q ? 2'b11 : be_q;
        if (bus.dc_resp) begin
          if (!wr_q) rdata_d = bus.dc_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.resp          = (state_q == DONE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.rdata         = rdata_q;
  assign bus.indirect_data = ind_data_q;

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// tb/tb_dcache_access_ctrl.sv - directed and randomized checks of dcache_access_ctrl
module tb_dcache_access_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [15:0] m_rdata;
  logic [15:0] m_ind;

  dcache_access_ctrl_if bus ();

  dcache_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dc_read"},   16'(bus.dc_read), 16'h0);
    chk({tag, " dc_write"},  16'(bus.dc_write), 16'h0);
    chk({tag, " dc_addr"},   bus.dc_address, 16'h0);
    chk({tag, " dc_wdata"},  bus.dc_wdata, 16'h0);
    chk({tag, " dc_be"},     16'(bus.dc_byte_enable), 16'h0);
    chk({tag, " resp"},      16'(bus.resp), 16'h0);
    chk({tag, " rdata"},     bus.rdata, 16'h0);
    chk({tag, " ind_data"},  bus.indirect_data, 16'h0);
    chk({tag, " busy"},      16'(bus.busy), 16'h0);
  endtask

  // Idle cycles with stray dcache responses that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle busy",   16'(bus.busy), 16'h0);
      chk("idle resp",   16'(bus.resp), 16'h0);
      chk("idle strobe", 16'({bus.dc_read, bus.dc_write}), 16'h0);
      chk("idle rdata",  bus.rdata, m_rdata);
      bus.dc_resp  = 1'($urandom_range(0, 1));
      bus.dc_rdata = 16'($urandom);
      @(negedge clk);
    end
    bus.dc_resp = 1'b0;
  endtask

  // One dcache access as seen on the port: strobe held until dc_resp after d wait cycles.
  task automatic strobe_phase(input logic exp_rd, input logic exp_wr, input logic [15:0] a,
                              input logic [1:0] be, input logic [15:0] wd, input int d,
                              input logic [15:0] data, input string tag);
    for (int k = 0; k <= d; k++) begin
      chk({tag, " dc_read"},  16'(bus.dc_read), 16'(exp_rd));
      chk({tag, " dc_write"}, 16'(bus.dc_write), 16'(exp_wr));
      chk({tag, " dc_addr"},  bus.dc_address, a);
      chk({tag, " dc_be"},    16'(bus.dc_byte_enable), 16'(be));
      if (exp_wr) chk({tag, " dc_wdata"}, bus.dc_wdata, wd);
      chk({tag, " resp"}, 16'(bus.resp), 16'h0);
      chk({tag, " busy"}, 16'(bus.busy), 16'h1);
      if (k == 0) begin
        bus.req_address     = 16'($urandom);
        bus.req_wdata       = 16'($urandom);
        bus.req_byte_enable = 2'($urandom);
      end
      bus.dc_resp  = (k == d);
      bus.dc_rdata = (k == d) ? data : 16'($urandom);
      @(negedge clk);
    end
    bus.dc_resp = 1'b0;
  endtask

  // Full transaction, starting and ending at the falling edge of an IDLE cycle.
  task automatic txn(input logic rd, input logic wr, input logic ind, input logic [15:0] addr,
                     input logic [15:0] wd, input logic [1:0] be, input logic [15:0] ptr,
                     input logic [15:0] fin, input int d1, input int d2, input logic drop);
    logic        is_wr;
    logic [15:0] fa;
    logic [1:0]  fbe;
    bus.req_read        = rd;
    bus.req_write       = wr;
    bus.req_indirect    = ind;
    bus.req_address     = addr;
    bus.req_wdata       = wd;
    bus.req_byte_enable = be;
    chk("start busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    is_wr = wr;
    if (ind) begin
      strobe_phase(1'b1, 1'b0, addr & 16'hFFFE, 2'b11, 16'h0, d1, ptr, "ptr");
      m_ind = ptr;
      chk("ptr ind_data", bus.indirect_data, m_ind);
      fa  = ptr & 16'hFFFE;
      fbe = 2'b11;
    end else begin
      fa  = addr;
      fbe = be;
    end
    strobe_phase(~is_wr, is_wr, fa, fbe, wd, d2, fin, "acc");
    if (!is_wr) m_rdata = fin;
    chk("done resp",     16'(bus.resp), 16'h1);
    chk("done rdata",    bus.rdata, m_rdata);
    chk("done ind_data", bus.indirect_data, m_ind);
    chk("done strobe",   16'({bus.dc_read, bus.dc_write}), 16'h0);
    chk("done dc_addr",  bus.dc_address, 16'h0);
    chk("done busy",     16'(bus.busy), 16'h1);
    if (drop) begin
      bus.req_read  = 1'b0;
      bus.req_write = 1'b0;
    end
    @(negedge clk);
    chk("after resp",  16'(bus.resp), 16'h0);
    chk("after busy",  16'(bus.busy), 16'h0);
    chk("after rdata", bus.rdata, m_rdata);
  endtask

  initial begin
    logic rd, wr;
    n_vec = 0;
    n_bad = 0;
    m_rdata = 16'h0;
    m_ind   = 16'h0;
    reset = 1'b1;
    bus.req_read = 1'b0;
    bus.req_write = 1'b0;
    bus.req_indirect = 1'b0;
    bus.req_address = 16'h0;
    bus.req_wdata = 16'h0;
    bus.req_byte_enable = 2'b00;
    bus.dc_rdata = 16'h0;
    bus.dc_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    txn(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'b11, 16'h0, 16'hBEEF, 0, 2, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 16'h2001, 16'h00AB, 2'b10, 16'h0, 16'h5A5A, 0, 0, 1'b1);
    idle_cycles(2);
    txn(1'b1, 1'b0, 1'b1, 16'h3001, 16'h0000, 2'b01, 16'h4567, 16'h9999, 1, 1, 1'b1);
    txn(1'b0, 1'b1, 1'b1, 16'h5000, 16'h1111, 2'b01, 16'h6000, 16'h7777, 0, 2, 1'b1);

    // Reset abandons a pointer fetch in flight.
    bus.req_read = 1'b1;
    bus.req_indirect = 1'b1;
    bus.req_address = 16'h7003;
    @(negedge clk);
    chk("rst ptr dc_read", 16'(bus.dc_read), 16'h1);
    reset = 1'b1;
    bus.req_read = 1'b0;
    bus.req_indirect = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0;
    m_rdata = 16'h0;
    m_ind   = 16'h0;
    bus.dc_resp = 1'b1;
    bus.dc_rdata = 16'hDEAD;
    @(negedge clk);
    bus.dc_resp = 1'b0;
    chk("stray resp", 16'(bus.resp), 16'h0);
    chk("stray busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    chk("stray resp2", 16'(bus.resp), 16'h0);

    // Read+write is a write; a request held past resp starts exactly one more.
    txn(1'b1, 1'b1, 1'b0, 16'h0ACE, 16'hCAFE, 2'b01, 16'h0, 16'h1357, 0, 1, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 16'h0ACE, 16'hCAFE, 2'b01, 16'h0, 16'h1357, 0, 1, 1'b1);
    idle_cycles(4);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(rd, wr, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 2'($urandom),
          16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 2) == 0) begin
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        idle_cycles($urandom_range(1, 2));
      end
    end
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    @(negedge clk);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
